// File: rtl/cdb_arbiter.sv
// cdb_arbiter: collects results from N_SRC functional units into one holding
// slot each and broadcasts at most one per cycle on the registered CDB,
// picking among full slots round-robin.
module cdb_arbiter #(
  parameter int unsigned N_SRC = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_flush,
  input  logic [N_SRC-1:0]       i_src_valid,
  input  logic [16*N_SRC-1:0]    i_src_data,
  input  logic [3*N_SRC-1:0]     i_src_tag,
  output logic [N_SRC-1:0]       o_src_ready,
  output logic                   o_cdb_valid,
  output logic [15:0]            o_cdb_data,
  output logic [2:0]             o_cdb_tag,
  output logic                   o_busy
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned TAG_W  = 3;
  localparam int unsigned PTR_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } result_t;

  result_t            r_slot [N_SRC];
  logic [N_SRC-1:0]   r_full;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic               r_cdb_valid;
  logic [DATA_W-1:0]  r_cdb_data;
  logic [TAG_W-1:0]   r_cdb_tag;

  result_t            w_in [N_SRC];
  logic [N_SRC-1:0]   w_grant;
  logic               w_grant_any;
  logic [PTR_W-1:0]   w_grant_idx;
  logic [PTR_W-1:0]   w_scan_idx;
  logic [N_SRC-1:0]   w_accept;

  // Unpack the flat per-unit result buses.
  always_comb begin
    for (int unsigned i = 0; i < N_SRC; i++) begin
      w_in[i].data = i_src_data[DATA_W*i +: DATA_W];
      w_in[i].tag  = i_src_tag[TAG_W*i +: TAG_W];
    end
  end

  // Round-robin search: first full slot starting at r_rr_ptr wins.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    w_scan_idx  = '0;
    w_grant     = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      w_scan_idx = PTR_W'((32'(r_rr_ptr) + k) % N_SRC);
      if (!w_grant_any && r_full[w_scan_idx]) begin
        w_grant_any = 1'b1;
        w_grant_idx = w_scan_idx;
      end
    end
    if (w_grant_any) begin
      w_grant[w_grant_idx] = 1'b1;
    end
  end

  // A slot being drained this cycle can take a new result in the same cycle.
  assign o_src_ready = {N_SRC{~i_flush}} & (~r_full | w_grant);
  assign w_accept    = i_src_valid & o_src_ready;
  assign o_busy      = |r_full;

  // Holding slots: load on handshake, clear on grant, drop all on flush.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_full <= '0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
        r_slot[i] <= '0;
      end
    end else if (i_flush) begin
      r_full <= '0;
    end else begin
      for (int unsigned i = 0; i < N_SRC; i++) begin
        if (w_accept[i]) begin
          r_full[i] <= 1'b1;
          r_slot[i] <= w_in[i];
        end else if (w_grant[i]) begin
          r_full[i] <= 1'b0;
        end
      end
    end
  end

  // CDB output register and round-robin pointer; a flush discards the grant.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cdb_valid <= 1'b0;
      r_cdb_data  <= '0;
      r_cdb_tag   <= '0;
      r_rr_ptr    <= '0;
    end else if (i_flush) begin
      r_cdb_valid <= 1'b0;
    end else begin
      r_cdb_valid <= w_grant_any;
      if (w_grant_any) begin
        r_cdb_data <= r_slot[w_grant_idx].data;
        r_cdb_tag  <= r_slot[w_grant_idx].tag;
        r_rr_ptr   <= (w_grant_idx == PTR_W'(N_SRC - 1)) ? '0 : w_grant_idx + PTR_W'(1);
      end
    end
  end

  assign o_cdb_valid = r_cdb_valid;
  assign o_cdb_data  = r_cdb_data;
  assign o_cdb_tag   = r_cdb_tag;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus a randomized
// run compared cycle by cycle against a behavioural slot/round-robin model.
module tb_cdb_arbiter;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [3:0]  valid;
  logic [63:0] data;
  logic [11:0] tag;
  logic [3:0]  ready;
  logic        cdb_valid;
  logic [15:0] cdb_data;
  logic [2:0]  cdb_tag;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic        m_full [N];
  logic [15:0] m_data [N];
  logic [2:0]  m_tag  [N];
  logic        m_acc  [N];
  int          m_rr;
  logic        m_cdb_valid;
  logic [15:0] m_cdb_data;
  logic [2:0]  m_cdb_tag;

  always #5 clk = ~clk;

  cdb_arbiter #(.N_SRC(N)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_flush     (flush),
    .i_src_valid (valid),
    .i_src_data  (data),
    .i_src_tag   (tag),
    .o_src_ready (ready),
    .o_cdb_valid (cdb_valid),
    .o_cdb_data  (cdb_data),
    .o_cdb_tag   (cdb_tag),
    .o_busy      (busy)
  );

  function automatic int m_grant();
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_rr + k) % N;
      if (m_full[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [3:0] m_ready();
    logic [3:0] r;
    int g;
    g = m_grant();
    for (int i = 0; i < N; i++) r[i] = !flush && (!m_full[i] || g == i);
    return r;
  endfunction

  function automatic logic m_busy();
    logic b;
    b = 1'b0;
    for (int i = 0; i < N; i++) b = b | m_full[i];
    return b;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_full[i] = 1'b0; m_data[i] = '0; m_tag[i] = '0; m_acc[i] = 1'b0;
    end
    m_rr = 0; m_cdb_valid = 1'b0; m_cdb_data = '0; m_cdb_tag = '0;
  endtask

  // Advance the model by one clock edge using the inputs presented this cycle.
  task automatic model_edge();
    int g;
    g = m_grant();
    for (int i = 0; i < N; i++) m_acc[i] = valid[i] && !flush && (!m_full[i] || g == i);
    if (flush) begin
      for (int i = 0; i < N; i++) m_full[i] = 1'b0;
      m_cdb_valid = 1'b0;
    end else begin
      if (g >= 0) begin
        m_cdb_valid = 1'b1;
        m_cdb_data  = m_data[g];
        m_cdb_tag   = m_tag[g];
        m_full[g]   = 1'b0;
        m_rr        = (g + 1) % N;
      end else begin
        m_cdb_valid = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (m_acc[i]) begin
          m_full[i] = 1'b1;
          m_data[i] = data[16*i +: 16];
          m_tag[i]  = tag[3*i +: 3];
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; valid = '0; flush = 1'b0;
    m_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; valid = '0; data = '0; tag = '0;
    m_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", cdb_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (cdb_tag !== 3'd0) begin errors++; $display("FAIL reset_tag: got %0d expected 0", cdb_tag); end
    @(negedge clk); reset = 1'b0;
    #1;
    checks++; if (ready !== 4'b1111) begin errors++; $display("FAIL reset_ready: got %b expected 1111", ready); end
    // Load two slots, let one broadcast, then reset between edges.
    @(negedge clk);
    valid = 4'b0011; data[15:0] = 16'hAAAA; data[31:16] = 16'hBBBB; tag[2:0] = 3'd3; tag[5:3] = 3'd4;
    step();
    @(negedge clk); valid = '0;
    step();
    checks++; if (cdb_valid !== 1'b1 || cdb_tag !== 3'd3 || busy !== 1'b1) begin
      errors++; $display("FAIL reset_preload: got valid=%b tag=%0d busy=%b expected 1/3/1", cdb_valid, cdb_tag, busy); end
    #2 reset = 1'b1;
    #1;
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %b expected 0", cdb_valid); end
    checks++; if (cdb_tag !== 3'd0 || cdb_data !== 16'h0) begin errors++; $display("FAIL async_tagdata: got %0d/%h expected 0/0000", cdb_tag, cdb_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_busy: got %b expected 0", busy); end
    m_reset();
    @(negedge clk); reset = 1'b0;
    #1;
    checks++; if (ready !== 4'b1111) begin errors++; $display("FAIL async_ready: got %b expected 1111", ready); end
    step();
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL async_no_pulse: got %b expected 0", cdb_valid); end
  endtask

  task automatic test_single();
    @(negedge clk);
    valid = 4'b0100; data[47:32] = 16'h1234; tag[8:6] = 3'd5;
    step();
    @(negedge clk); valid = '0;
    #1;
    checks++; if (cdb_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL single_t1: got valid=%b busy=%b expected 0/1", cdb_valid, busy); end
    step();
    checks++; if (cdb_valid !== 1'b1 || cdb_data !== 16'h1234 || cdb_tag !== 3'd5) begin
      errors++; $display("FAIL single_t2: got %b/%h/%0d expected 1/1234/5", cdb_valid, cdb_data, cdb_tag); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b expected 0", busy); end
    checks++; if (int'(dut.r_rr_ptr) !== 3) begin errors++; $display("FAIL single_rr: got %0d expected 3", dut.r_rr_ptr); end
    step();
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL single_t3: got %b expected 0", cdb_valid); end
  endtask

  task automatic test_contention();
    logic [15:0] exp_d [N];
    do_reset();
    @(negedge clk);
    valid = 4'b1111;
    for (int i = 0; i < N; i++) begin
      exp_d[i] = 16'($urandom);
      data[16*i +: 16] = exp_d[i];
      tag[3*i +: 3] = 3'(i);
    end
    #1;
    checks++; if (ready !== 4'b1111) begin errors++; $display("FAIL cont_ready0: got %b expected 1111", ready); end
    step();
    @(negedge clk); valid = '0;
    #1;
    checks++; if (ready !== 4'b0001) begin errors++; $display("FAIL cont_ready1: got %b expected 0001", ready); end
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL cont_early: got %b expected 0", cdb_valid); end
    for (int k = 0; k < N; k++) begin
      step();
      checks++; if (cdb_valid !== 1'b1 || cdb_tag !== 3'(k) || cdb_data !== exp_d[k]) begin
        errors++; $display("FAIL cont_order%0d: got %b/%0d/%h expected 1/%0d/%h", k, cdb_valid, cdb_tag, cdb_data, k, exp_d[k]); end
      if (k == 0) begin
        checks++; if (ready[0] !== 1'b1) begin errors++; $display("FAIL cont_ready_ret: got %b expected 1", ready[0]); end
      end
    end
    step();
    checks++; if (cdb_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL cont_end: got valid=%b busy=%b expected 0/0", cdb_valid, busy); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] sd [6];
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c < 6) begin
        sd[c] = 16'($urandom);
        valid = 4'b0010; data[31:16] = sd[c]; tag[5:3] = 3'(c + 1);
        #1;
        checks++; if (ready[1] !== 1'b1) begin errors++; $display("FAIL stream_ready%0d: got %b expected 1", c, ready[1]); end
      end else begin
        valid = '0;
      end
      step();
      if (c >= 1 && c <= 6) begin
        checks++; if (cdb_valid !== 1'b1 || cdb_tag !== 3'(c) || cdb_data !== sd[c-1]) begin
          errors++; $display("FAIL stream_pulse%0d: got %b/%0d/%h expected 1/%0d/%h", c, cdb_valid, cdb_tag, cdb_data, c, sd[c-1]); end
      end else begin
        checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL stream_idle%0d: got %b expected 0", c, cdb_valid); end
      end
    end
  endtask

  task automatic test_flush();
    int rr_before;
    @(negedge clk);
    valid = 4'b1001; data[15:0] = 16'h0F0F; tag[2:0] = 3'd2; data[63:48] = 16'hF0F0; tag[11:9] = 3'd7;
    step();
    rr_before = m_rr;
    @(negedge clk); valid = '0; flush = 1'b1;
    #1;
    checks++; if (ready !== 4'b0000) begin errors++; $display("FAIL flush_ready: got %b expected 0000", ready); end
    step();
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", cdb_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", busy); end
    @(negedge clk); flush = 1'b0;
    step();
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL flush_after: got %b expected 0", cdb_valid); end
    checks++; if (int'(dut.r_rr_ptr) !== rr_before) begin errors++; $display("FAIL flush_rr: got %0d expected %0d", dut.r_rr_ptr, rr_before); end
  endtask

  task automatic test_rr_wrap();
    @(negedge clk);
    valid = 4'b0100; data[47:32] = 16'h2222; tag[8:6] = 3'd1;
    step();
    @(negedge clk); valid = '0;
    step();
    checks++; if (int'(dut.r_rr_ptr) !== 3) begin errors++; $display("FAIL wrap_rr3: got %0d expected 3", dut.r_rr_ptr); end
    @(negedge clk);
    valid = 4'b1001; data[15:0] = 16'h0000; tag[2:0] = 3'd7; data[63:48] = 16'h3333; tag[11:9] = 3'd6;
    step();
    @(negedge clk); valid = '0;
    step();
    checks++; if (cdb_valid !== 1'b1 || cdb_tag !== 3'd6 || cdb_data !== 16'h3333) begin
      errors++; $display("FAIL wrap_first: got %b/%0d/%h expected 1/6/3333", cdb_valid, cdb_tag, cdb_data); end
    step();
    checks++; if (cdb_valid !== 1'b1 || cdb_tag !== 3'd7 || cdb_data !== 16'h0000) begin
      errors++; $display("FAIL wrap_second: got %b/%0d/%h expected 1/7/0000", cdb_valid, cdb_tag, cdb_data); end
    checks++; if (int'(dut.r_rr_ptr) !== 1) begin errors++; $display("FAIL wrap_rr1: got %0d expected 1", dut.r_rr_ptr); end
    step();
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      flush = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < N; i++) begin
        if (!valid[i] || m_acc[i]) begin
          valid[i] = 1'($urandom_range(0, 1));
          data[16*i +: 16] = 16'($urandom);
          tag[3*i +: 3] = 3'($urandom);
        end
      end
      #1;
      checks++; if (ready !== m_ready()) begin errors++; $display("FAIL rand_ready@%0d: got %b expected %b", cyc, ready, m_ready()); end
      step();
      checks++; if (cdb_valid !== m_cdb_valid || cdb_data !== m_cdb_data || cdb_tag !== m_cdb_tag) begin
        errors++; $display("FAIL rand_cdb@%0d: got %b/%h/%0d expected %b/%h/%0d", cyc, cdb_valid, cdb_data, cdb_tag, m_cdb_valid, m_cdb_data, m_cdb_tag); end
      checks++; if (busy !== m_busy()) begin errors++; $display("FAIL rand_busy@%0d: got %b expected %b", cyc, busy, m_busy()); end
    end
    @(negedge clk); valid = '0; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_flush();
    test_rr_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Transmit side of the common data bus (CDB) in the out-of-order core.
- Collects completed results from N_SRC functional units, each as a 16-bit value plus a 3-bit ROB tag.
- Buffers one result per unit and broadcasts at most one result per cycle on the registered CDB (valid/data/tag).
- Reservation stations, register file and ROB consume the broadcast without backpressure.

Parameters:
- N_SRC, 4, number of producing functional units (ALU, shifter, load/store, branch); 2..8.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- flush  in  1  ROB mispredict/flush; discards all buffered and outgoing results
- src_valid  in  N_SRC  unit i presents a result
- src_data  in  16*N_SRC  result value; unit i at bits [16i+15:16i]
- src_tag  in  3*N_SRC  ROB entry of the result; unit i at bits [3i+2:3i]
- src_ready  out  N_SRC  arbiter accepts unit i's result this cycle
- cdb_valid  out  1  CDB broadcast valid
- cdb_data  out  16  CDB broadcast value
- cdb_tag  out  3  CDB broadcast ROB tag
- busy  out  1  at least one holding slot is full

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values:
  - all slots empty;
  - cdb_valid=0, cdb_data=16'h0000, cdb_tag=3'b000;
  - rr_ptr=0;
  - busy=0;
  - src_ready follows from the empty slots, i.e. all 1 once reset is low.
- Reset asserted mid-operation drops every held result immediately; there is no partial broadcast.
- Per-unit holding slot: full bit, 16-bit data, 3-bit tag.
- Accept (handshake) rule:
  - A result is accepted on a rising edge where src_valid[i] & src_ready[i].
  - At that edge the slot loads data/tag and sets full.
  - src_valid without src_ready: the unit must hold its data/tag stable until accepted.
- src_ready[i] = ~flush & (~full[i] | grant[i]). This is combinational from slot state, rr_ptr and flush.
  - A unit that wins every cycle can therefore stream one result per cycle.
- Arbitration (combinational, each cycle):
  - Search full slots in order rr_ptr, rr_ptr+1, ... modulo N_SRC.
  - The first full slot found is granted; at most one grant per cycle.
  - No grant when no slot is full.
- On the edge after a grant to slot g:
  - cdb_valid=1 with cdb_data/cdb_tag taken from slot g;
  - slot g clears, unless it reloads in the same cycle via the accept rule;
  - rr_ptr = (g+1) mod N_SRC.
- No grant: cdb_valid=0 next cycle; cdb_data/cdb_tag hold their last values; rr_ptr unchanged.
- cdb_valid is a per-result pulse of exactly one cycle. Each accepted result is broadcast exactly once unless flushed.
- Latency:
  - handshake in cycle t → slot full in t+1 → earliest CDB visibility in cycle t+2;
  - worst case: a full slot waits at most N_SRC-1 grants.
- Flush:
  - In the flush cycle, src_ready=0 for all units.
  - At the edge: all slots clear, cdb_valid=0, rr_ptr unchanged.
  - A grant computed during the flush cycle is discarded.
- Simultaneous grant and reload of the same slot: the new result occupies the slot and the old one goes to the CDB; no loss and no duplication.
- busy = OR of slot full bits (registered state, combinational OR).
- Tag values are passed through unmodified; two units holding the same tag is legal and not checked.

Test Plan:
- Reset: assert reset asynchronously between edges → cdb_valid=0, cdb_tag=0, busy=0 immediately; src_ready=4'b1111 after release.
- Single result:
  - stimulus: unit 2 presents data 16'h1234, tag 3'd5 for one cycle, handshake in cycle t;
  - response: cdb_valid=1, cdb_data=16'h1234, cdb_tag=5 in cycle t+2 only; rr_ptr=3; busy low again in t+2.
- Contention/fairness:
  - stimulus: all 4 units hand off in the same cycle with tags 0,1,2,3, rr_ptr=0, then stop;
  - response: CDB shows tags 0,1,2,3 on four consecutive cycles; src_ready[0] returns high one cycle after its grant.
- Streaming: unit 1 alone presents a new result every cycle (tags 1..6) → src_ready[1] stays high; six back-to-back CDB pulses in order with no bubbles.
- Flush:
  - stimulus: fill slots 0 and 3, assert flush for one cycle before either slot is broadcast;
  - response: src_ready=0 during flush; no CDB pulse carries those tags; busy=0 after the edge.
- Round-robin wrap:
  - stimulus: rr_ptr=3, slots 0 and 3 full;
  - response: slot 3 is broadcast first, then slot 0; rr_ptr ends at 1.
